// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector, NOP value,
// FSM encodings and the buffered fetch pair type.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pair_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if_fifo2.sv
// Two-entry buffer of fetched {pc, inst} pairs sitting between imem and decode.
// Flush empties it in one cycle; the caller guarantees no push when full.
module if_fifo2
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fetch_pair_t push_data,
    input  logic        pop,
    output logic [1:0]  count,
    output fetch_pair_t head
);

    fetch_pair_t mem_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding imem request, 2-entry buffer, decode register.
// Optional IF_ALIGN_CHECK_EN turns a misaligned redirect into an exception slot.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_excp_o
);

    logic [1:0]  state_r, state_nx_s;
    logic [31:0] fetch_pc_r, fetch_pc_nx_s;
    logic        req_r, req_nx_s;
    logic [31:0] addr_r, addr_nx_s;
    logic        halt_r, halt_nx_s;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    logic        id_valid_r;

    logic        misalign_s;
    logic [31:0] target_pc_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        bypass_s;
    logic [1:0]  fifo_count_s;
    logic [1:0]  count_nx_s;
    fetch_pair_t fifo_head_s;
    fetch_pair_t fetch_pair_s;

`ifdef IF_ALIGN_CHECK_EN
    assign misalign_s  = (new_pc_i[1:0] != 2'b00);
    assign target_pc_s = new_pc_i;
`else
    assign misalign_s  = 1'b0;
    assign target_pc_s = {new_pc_i[31:2], 2'b00};
`endif

    // Acks in DRAIN, IDLE or alongside a flush belong to a stale stream.
    assign accept_s     = (state_r == ST_REQ) && imem_ack_i && !flush_i;
    assign pop_s        = !flush_i && !stall_i && (fifo_count_s != 2'd0);
    assign bypass_s     = accept_s && !stall_i && (fifo_count_s == 2'd0);
    assign push_s       = accept_s && !bypass_s;
    assign count_nx_s   = fifo_count_s + {1'b0, push_s} - {1'b0, pop_s};
    assign fetch_pair_s = '{pc: addr_r, inst: imem_rdata_i};

    if_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push_s),
        .push_data (fetch_pair_s),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Request FSM: a request is issued only if the buffer can absorb its data.
    always_comb begin
        state_nx_s    = state_r;
        req_nx_s      = req_r;
        addr_nx_s     = addr_r;
        fetch_pc_nx_s = fetch_pc_r;
        halt_nx_s     = halt_r;
        if (flush_i) begin
            fetch_pc_nx_s = target_pc_s;
            halt_nx_s     = misalign_s;
            if (req_r && !imem_ack_i) begin
                state_nx_s = ST_DRAIN;
            end else if (misalign_s) begin
                state_nx_s = ST_IDLE;
                req_nx_s   = 1'b0;
            end else begin
                state_nx_s = ST_REQ;
                req_nx_s   = 1'b1;
                addr_nx_s  = target_pc_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!halt_r && (count_nx_s != 2'd2)) begin
                        state_nx_s = ST_REQ;
                        req_nx_s   = 1'b1;
                        addr_nx_s  = fetch_pc_r;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        fetch_pc_nx_s = pc_incr(fetch_pc_r);
                        if (count_nx_s != 2'd2) begin
                            addr_nx_s = pc_incr(fetch_pc_r);
                        end else begin
                            state_nx_s = ST_IDLE;
                            req_nx_s   = 1'b0;
                        end
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack_i && halt_r) begin
                        state_nx_s = ST_IDLE;
                        req_nx_s   = 1'b0;
                    end else if (imem_ack_i) begin
                        state_nx_s = ST_REQ;
                        addr_nx_s  = fetch_pc_r;
                    end else begin
                        state_nx_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    req_nx_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            fetch_pc_r <= RESET_PC;
            halt_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            req_r      <= req_nx_s;
            addr_r     <= addr_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            halt_r     <= halt_nx_s;
        end
    end

    // Decode register: flush beats stall, buffer head beats the bypass path.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (flush_i) begin
            id_pc_r    <= misalign_s ? new_pc_i : id_pc_r;
            id_inst_r  <= NOP_INST;
            id_valid_r <= misalign_s;
        end else if (stall_i) begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= id_inst_r;
            id_valid_r <= id_valid_r;
        end else if (pop_s) begin
            id_pc_r    <= fifo_head_s.pc;
            id_inst_r  <= fifo_head_s.inst;
            id_valid_r <= 1'b1;
        end else if (bypass_s) begin
            id_pc_r    <= addr_r;
            id_inst_r  <= imem_rdata_i;
            id_valid_r <= 1'b1;
        end else begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic id_excp_r;

    // Exception flag accompanies only the misaligned-redirect slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_excp_r <= 1'b0;
        end else if (flush_i) begin
            id_excp_r <= misalign_s;
        end else if (stall_i) begin
            id_excp_r <= id_excp_r;
        end else begin
            id_excp_r <= 1'b0;
        end
    end

    assign id_excp_o = id_excp_r;
`else
    assign id_excp_o = 1'b0;
`endif

    assign imem_req_o  = req_r;
    assign imem_addr_o = addr_r;
    assign id_pc_o     = id_pc_r;
    assign id_inst_o   = id_inst_r;
    assign id_valid_o  = id_valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// stream checked against an in-order program-counter reference model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_excp_o;

    int test_cnt = 0;
    int fail_cnt = 0;
    int ack_mode = 0;   // 0 zero-wait, 1 random waits, 2 never, 3 always high

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_valid_o   (id_valid_o),
        .id_excp_o    (id_excp_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Advance one cycle and drive the memory response for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        case (ack_mode)
            0:       imem_ack_i = imem_req_o;
            1:       imem_ack_i = imem_req_o && ($urandom_range(0, 2) != 0);
            3:       imem_ack_i = 1'b1;
            default: imem_ack_i = 1'b0;
        endcase
        imem_rdata_i = mem_word(imem_addr_o);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'h0; ack_mode = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(); step(); step();
        ack_mode = 3;
        rst = 1'b1;
        step(); step();
        test_cnt += 5;
        if (imem_req_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
        if (imem_addr_o !== 32'h0) begin fail_cnt++; $display("FAIL rst_addr got %h exp 0", imem_addr_o); end
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin fail_cnt++; $display("FAIL rst_id got %h/%h exp 0/0", id_pc_o, id_inst_o); end
        if (id_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid got %b exp 0", id_valid_o); end
        if (id_excp_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_excp got %b exp 0", id_excp_o); end
        rst = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        test_cnt++;
        if (imem_req_o !== 1'b0) begin fail_cnt++; $display("FAIL post_rst_req got %b exp 0", imem_req_o); end
        ack_mode = 0;
        step();
        test_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin
            fail_cnt++; $display("FAIL first_req got req=%b addr=%h v=%b exp 1/0/0", imem_req_o, imem_addr_o, id_valid_o);
        end
        step();
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== mem_word(32'h0)) begin
            fail_cnt++; $display("FAIL stale_ack got v=%b pc=%h inst=%h exp 1/0/%h", id_valid_o, id_pc_o, id_inst_o, mem_word(32'h0));
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_pc = (c - 2) * 4;
            test_cnt++;
            if (c < 2) begin
                if (id_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL zw_valid c%0d got %b exp 0", c, id_valid_o); end
            end else if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc || id_inst_o !== mem_word(exp_pc)) begin
                fail_cnt++; $display("FAIL zw_pc c%0d got v=%b pc=%h inst=%h exp 1/%h/%h", c, id_valid_o, id_pc_o, id_inst_o, exp_pc, mem_word(exp_pc));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step(); step();
        stall_i = 1'b1;
        for (int c = 5; c <= 7; c++) begin
            step();
            if (c == 7) stall_i = 1'b0;
            test_cnt++;
            if (id_pc_o !== 32'h8 || id_valid_o !== 1'b1) begin
                fail_cnt++; $display("FAIL stall_hold c%0d got pc=%h v=%b exp 8/1", c, id_pc_o, id_valid_o);
            end
            if (c >= 6) begin
                test_cnt++;
                if (imem_req_o !== 1'b0) begin fail_cnt++; $display("FAIL stall_req c%0d got %b exp 0", c, imem_req_o); end
            end
        end
        for (int c = 8; c <= 9; c++) begin
            step();
            test_cnt++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 32'h4 * c - 32'h14 || id_inst_o !== mem_word(32'h4 * c - 32'h14)) begin
                fail_cnt++; $display("FAIL stall_release c%0d got v=%b pc=%h exp 1/%h", c, id_valid_o, id_pc_o, 32'h4 * c - 32'h14);
            end
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        ack_mode = 2;
        flush_i = 1'b1; new_pc_i = 32'h20;
        step();
        test_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20) begin
            fail_cnt++; $display("FAIL fw_req got %b/%h exp 1/20", imem_req_o, imem_addr_o);
        end
        new_pc_i = 32'h100;
        step();
        flush_i = 1'b0;
        test_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20) begin
            fail_cnt++; $display("FAIL fw_hold got %b/%h exp 1/20", imem_req_o, imem_addr_o);
        end
        step();
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        test_cnt++;
        if (imem_addr_o !== 32'h20) begin fail_cnt++; $display("FAIL fw_hold2 got %h exp 20", imem_addr_o); end
        step();
        test_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || id_valid_o !== 1'b0) begin
            fail_cnt++; $display("FAIL fw_redirect got %b/%h v=%b exp 1/100/0", imem_req_o, imem_addr_o, id_valid_o);
        end
        ack_mode = 0;
        imem_ack_i = imem_req_o; imem_rdata_i = mem_word(imem_addr_o);
        step();
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || id_inst_o !== mem_word(32'h100)) begin
            fail_cnt++; $display("FAIL fw_first got v=%b pc=%h inst=%h exp 1/100/%h", id_valid_o, id_pc_o, id_inst_o, mem_word(32'h100));
        end
    endtask

    task automatic test_flush_stall_full();
        do_reset();
        step(); step(); step(); step();
        stall_i = 1'b1;
        step(); step(); step();
        test_cnt++;
        if (imem_req_o !== 1'b0) begin fail_cnt++; $display("FAIL fsf_full got req=%b exp 0", imem_req_o); end
        flush_i = 1'b1; new_pc_i = 32'h200;
        step();
        flush_i = 1'b0; stall_i = 1'b0;
        test_cnt++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h8 || id_inst_o !== 32'h0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            fail_cnt++; $display("FAIL fsf_bubble got v=%b pc=%h req=%b addr=%h exp 0/8/1/200", id_valid_o, id_pc_o, imem_req_o, imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            test_cnt++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200 + 32'h4 * k) begin
                fail_cnt++; $display("FAIL fsf_resume k%0d got v=%b pc=%h exp 1/%h", k, id_valid_o, id_pc_o, 32'h200 + 32'h4 * k);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        test_cnt++;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin fail_cnt++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr_o); end
        step();
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== mem_word(32'hFFFF_FFFC)) begin
            fail_cnt++; $display("FAIL wrap_top got v=%b pc=%h exp 1/fffffffc", id_valid_o, id_pc_o);
        end
        step();
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== mem_word(32'h0)) begin
            fail_cnt++; $display("FAIL wrap_zero got v=%b pc=%h exp 1/0", id_valid_o, id_pc_o);
        end
    endtask

    task automatic test_align();
        do_reset();
        flush_i = 1'b1; new_pc_i = 32'h102;
        step();
        flush_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_excp_o !== 1'b1 || id_pc_o !== 32'h102 || id_inst_o !== 32'h0 || imem_req_o !== 1'b0) begin
            fail_cnt++; $display("FAIL align_slot got v=%b x=%b pc=%h req=%b exp 1/1/102/0", id_valid_o, id_excp_o, id_pc_o, imem_req_o);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            test_cnt++;
            if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0 || id_excp_o !== 1'b0) begin
                fail_cnt++; $display("FAIL align_idle k%0d got req=%b v=%b x=%b exp 0/0/0", k, imem_req_o, id_valid_o, id_excp_o);
            end
        end
`else
        test_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || id_excp_o !== 1'b0) begin
            fail_cnt++; $display("FAIL align_force got req=%b addr=%h x=%b exp 1/100/0", imem_req_o, imem_addr_o, id_excp_o);
        end
        step();
        test_cnt++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100) begin
            fail_cnt++; $display("FAIL align_fetch got v=%b pc=%h exp 1/100", id_valid_o, id_pc_o);
        end
`endif
    endtask

    // Reference model: decode sees consecutive words from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, p_pc, p_inst, p_addr, p_newpc, tmp;
        logic        p_valid, p_stall, p_flush, p_req, p_ack;
        int          n_valid;
        do_reset();
        ack_mode = 1; exp_pc = 32'h0; n_valid = 0;
        for (int i = 0; i < 1500; i++) begin
            tmp      = $urandom();
            stall_i  = ($urandom_range(0, 3) == 0);
            flush_i  = ($urandom_range(0, 24) == 0);
            new_pc_i = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, tmp[1:0], 2'b00} : {tmp[31:2], 2'b00};
            p_stall = stall_i; p_flush = flush_i; p_newpc = new_pc_i;
            p_req = imem_req_o; p_addr = imem_addr_o; p_ack = imem_ack_i;
            p_pc = id_pc_o; p_inst = id_inst_o; p_valid = id_valid_o;
            step();
            if (p_req && !p_ack) begin
                test_cnt++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== p_addr) begin
                    fail_cnt++; $display("FAIL rnd_req_stable i%0d got %b/%h exp 1/%h", i, imem_req_o, imem_addr_o, p_addr);
                end
            end
            test_cnt++;
            if (id_excp_o !== 1'b0 || (imem_req_o && imem_addr_o[1:0] !== 2'b00)) begin
                fail_cnt++; $display("FAIL rnd_excp_align i%0d got x=%b addr=%h exp 0/aligned", i, id_excp_o, imem_addr_o);
            end
            test_cnt++;
            if (p_flush) begin
                exp_pc = p_newpc;
                if (id_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rnd_flush_bubble i%0d got v=%b exp 0", i, id_valid_o); end
            end else if (p_stall) begin
                if (id_pc_o !== p_pc || id_inst_o !== p_inst || id_valid_o !== p_valid) begin
                    fail_cnt++; $display("FAIL rnd_stall_hold i%0d got %h/%h/%b exp %h/%h/%b", i, id_pc_o, id_inst_o, id_valid_o, p_pc, p_inst, p_valid);
                end
            end else if (id_valid_o) begin
                if (id_pc_o !== exp_pc || id_inst_o !== mem_word(exp_pc)) begin
                    fail_cnt++; $display("FAIL rnd_stream i%0d got %h/%h exp %h/%h", i, id_pc_o, id_inst_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_valid++;
            end else if (id_pc_o !== p_pc || id_inst_o !== 32'h0) begin
                fail_cnt++; $display("FAIL rnd_bubble i%0d got %h/%h exp %h/0", i, id_pc_o, id_inst_o, p_pc);
            end
        end
        stall_i = 1'b0; flush_i = 1'b0;
        test_cnt++;
        if (n_valid < 200) begin fail_cnt++; $display("FAIL rnd_progress got %0d exp >=200", n_valid); end
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'h0;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_flush_wait();
        test_flush_stall_full();
        test_wrap();
        test_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
